// File: rtl/ucom_kbd_pkg.sv
// Shared constants and index helpers for the MCU key-matrix responder.
// The row width is tied to the 4-bit MCU input port.
package ucom_kbd_pkg;

  localparam int ROWS_C = 4;

  // Debounce counter width; a one-sample debouncer still needs a 1-bit counter.
  function automatic int cnt_width(input int deb_samples);
    return ($clog2(deb_samples) < 1) ? 1 : $clog2(deb_samples);
  endfunction

  function automatic int key_idx(input int c, input int r);
    return c * ROWS_C + r;
  endfunction

endpackage

// File: rtl/ucom_key_debounce.sv
// One key: 2-flop synchronizer, tick-driven debounce counter and accepted level.
// o_press is high in the cycle a 0->1 update of the accepted level is committed.
module ucom_key_debounce
  import ucom_kbd_pkg::*;
#(
  parameter int DEB_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_deb,
  output logic o_press
);

  localparam int            CW       = cnt_width(DEB_SAMPLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_SAMPLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  assign w_accept = i_tick && (r_sync2 != r_deb) && (r_cnt == CNT_LAST);
  assign o_press  = w_accept && r_sync2;
  assign o_deb    = r_deb;

  // NOTE: non-blocking assignments everywhere here so each flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (i_tick) begin
        if (r_sync2 == r_deb) begin
          r_cnt <= '0;
        end else if (w_accept) begin
          r_deb <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ucom_key_matrix.sv
// Key-matrix responder: debounces COLS*4 keys, returns strobed rows and pulses _INT on presses.
// Build option KEY_STICKY_EN latches each press until the MCU has finished strobing its column.
module ucom_key_matrix
  import ucom_kbd_pkg::*;
#(
  parameter int COLS        = 8,
  parameter int PRESCALE    = 256,
  parameter int DEB_SAMPLES = 4,
  parameter int INT_LEN     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COLS*ROWS_C-1:0] keys_raw,
  input  logic [COLS-1:0]        strobe,
  output logic [ROWS_C-1:0]      row_out,
  output logic                   int_n,
  output logic                   key_any
);

  localparam int            ROWS     = ROWS_C;
  localparam int            NK       = COLS * ROWS;
  localparam int            PW       = $clog2(PRESCALE);
  localparam int            IW       = $clog2(INT_LEN + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] INT_LOAD = IW'(INT_LEN);

  logic [PW-1:0]   r_pre;
  logic            w_tick;
  logic [NK-1:0]   w_deb;
  logic [NK-1:0]   w_press;
  logic [NK-1:0]   w_view;
  logic [ROWS-1:0] w_row;
  logic [ROWS-1:0] r_row_out;
  logic [IW-1:0]   r_int_cnt;
  logic            r_key_any;

  assign w_tick = (r_pre == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  for (genvar g = 0; g < NK; g++) begin : g_key
    ucom_key_debounce #(
      .DEB_SAMPLES (DEB_SAMPLES)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (keys_raw[g]),
      .i_tick  (w_tick),
      .o_deb   (w_deb[g]),
      .o_press (w_press[g])
    );
  end

`ifdef KEY_STICKY_EN
  logic [NK-1:0]   r_sticky;
  logic [COLS-1:0] r_strobe_d;
  logic [NK-1:0]   w_clr;

  // A column read ends when its strobe falls; that clears the column's sticky bits.
  always_comb begin
    w_clr = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        w_clr[key_idx(c, r)] = r_strobe_d[c] & ~strobe[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_strobe_d <= '0;
      r_sticky   <= '0;
    end else begin
      r_strobe_d <= strobe;
      r_sticky   <= w_press | (r_sticky & ~w_clr);
    end
  end

  assign w_view = w_deb | r_sticky;
`else
  assign w_view = w_deb;
`endif

  // No ghost filtering: several strobed columns simply OR together.
  always_comb begin
    // NOTE: default assignment first keeps this always_comb free of inferred latches.
    w_row = '0;
    for (int c = 0; c < COLS; c++) begin
      if (strobe[c]) begin
        w_row = w_row | w_view[key_idx(c, 0) +: ROWS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_out <= '0;
      r_key_any <= 1'b0;
      r_int_cnt <= '0;
    end else begin
      r_row_out <= w_row;
      r_key_any <= |w_deb;
      if (|w_press) begin
        r_int_cnt <= INT_LOAD;
      end else if (r_int_cnt != '0) begin
        r_int_cnt <= r_int_cnt - IW'(1);
      end
    end
  end

  assign row_out = r_row_out;
  assign key_any = r_key_any;
  // Reset forces _INT inactive without waiting for the clock edge.
  assign int_n   = reset | (r_int_cnt == '0);

endmodule

// File: tb/tb_ucom_key_matrix.sv
// Self-checking bench for ucom_key_matrix: directed steps plus randomized keys and strobes,
// compared every cycle against a behavioural model of the debounce, row read and _INT rules.
module tb_ucom_key_matrix;

  localparam int COLS     = 8;
  localparam int ROWS     = 4;
  localparam int PRESCALE = 4;
  localparam int DEB      = 3;
  localparam int INT_LEN  = 2;
  localparam int NK       = COLS * ROWS;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NK-1:0]   keys_raw = '0;
  logic [COLS-1:0] strobe = '0;
  logic [ROWS-1:0] row_out;
  logic            int_n;
  logic            key_any;

  // Second instance with a fast tick and a long pulse so two presses can overlap a pulse.
  logic [NK-1:0]   keys_b = '0;
  logic [COLS-1:0] strobe_b = '0;
  logic [ROWS-1:0] row_b;
  logic            int_n_b;
  logic            key_any_b;

  ucom_key_matrix #(
    .COLS(COLS), .PRESCALE(PRESCALE), .DEB_SAMPLES(DEB), .INT_LEN(INT_LEN)
  ) u_dut (
    .clk(clk), .reset(reset), .keys_raw(keys_raw), .strobe(strobe),
    .row_out(row_out), .int_n(int_n), .key_any(key_any)
  );

  ucom_key_matrix #(
    .COLS(COLS), .PRESCALE(2), .DEB_SAMPLES(1), .INT_LEN(3)
  ) u_dut_b (
    .clk(clk), .reset(reset), .keys_raw(keys_b), .strobe(strobe_b),
    .row_out(row_b), .int_n(int_n_b), .key_any(key_any_b)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Behavioural model state: accepted level and count of consecutive differing ticks per key.
  bit              m_deb    [NK];
  int              m_diff   [NK];
  bit              m_sticky [NK];
  logic [NK-1:0]   m_s1, m_s2;
  logic [COLS-1:0] m_prev_strobe;
  int              cyc = 0;
  int              last_press = -1000;
  logic [ROWS-1:0] exp_row = '0;
  logic            exp_any = 1'b0;

  int n_int_low = 0;
  int run_b = 0, max_run_b = 0, n_low_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_tick();
    logic [COLS-1:0] fell;
    bit tick;
    bit press_any;
    if (reset) begin
      for (int k = 0; k < NK; k++) begin
        m_deb[k] = 1'b0; m_diff[k] = 0; m_sticky[k] = 1'b0;
      end
      m_s1 = '0; m_s2 = '0; m_prev_strobe = '0;
      cyc = 0; last_press = -1000; exp_row = '0; exp_any = 1'b0;
      return;
    end
    exp_row = '0;
    exp_any = 1'b0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) begin
        if (strobe[c] && (m_deb[c*ROWS+r] || m_sticky[c*ROWS+r])) exp_row[r] = 1'b1;
        if (m_deb[c*ROWS+r]) exp_any = 1'b1;
      end
    tick = (cyc % PRESCALE) == PRESCALE - 1;
    fell = m_prev_strobe & ~strobe;
    press_any = 1'b0;
    for (int k = 0; k < NK; k++) begin
      bit pressed;
      pressed = 1'b0;
      if (tick) begin
        if (m_s2[k] == m_deb[k]) m_diff[k] = 0;
        else if (m_diff[k] + 1 == DEB) begin
          m_deb[k] = m_s2[k];
          m_diff[k] = 0;
          pressed = m_deb[k];
        end else m_diff[k]++;
      end
`ifdef KEY_STICKY_EN
      if (pressed) m_sticky[k] = 1'b1;
      else if (fell[k / ROWS]) m_sticky[k] = 1'b0;
`endif
      if (pressed) press_any = 1'b1;
    end
    if (press_any) last_press = cyc;
    m_s2 = m_s1;
    m_s1 = keys_raw;
    m_prev_strobe = strobe;
    cyc++;
  endtask

  task automatic check_all();
    logic exp_int;
    exp_int = reset || !(cyc >= last_press + 1 && cyc <= last_press + INT_LEN);
    check("row_out", row_out, exp_row);
    check("int_n", int_n, exp_int);
    check("key_any", key_any, exp_any);
    if (!int_n) n_int_low++;
    if (int_n_b === 1'b0) begin
      n_low_b++;
      run_b++;
      if (run_b > max_run_b) max_run_b = run_b;
    end else run_b = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_tick();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic flush_sticky();
    strobe = '1; step(1);
    strobe = '0; step(1);
  endtask

  initial begin
    bit found;

    // 1: reset with all keys held, then one pulse for the simultaneous acceptance
    keys_raw = '1;
    step(3);
    check("rst_row_out", row_out, 4'h0);
    check("rst_int_n", int_n, 1'b1);
    check("rst_key_any", key_any, 1'b0);
    reset = 1'b0;
    n_int_low = 0;
    step(14);
    check("t1_one_pulse", n_int_low, 2);
    check("t1_key_any", key_any, 1'b1);
    keys_raw = '0;
    step(16);
    flush_sticky();

    // 2: single key c2 r1
    keys_raw = NK'(1) << 9;
    strobe = 8'h04;
    step(16);
    check("t2_row_c2", row_out, 4'b0010);
    strobe = 8'h01;
    step(1);
    check("t2_row_c0", row_out, 4'b0000);
    keys_raw = '0; strobe = '0;
    step(16);
    flush_sticky();

    // 3: glitch shorter than the debounce window
    n_int_low = 0;
    keys_raw = NK'(1);
    step(6);
    keys_raw = '0;
    step(16);
    strobe = 8'h01;
    step(1);
    check("t3_no_int", n_int_low, 0);
    check("t3_row", row_out, 4'b0000);
    check("t3_key_any", key_any, 1'b0);
    strobe = '0;

    // 4: two keys in two strobed columns
    keys_raw = (NK'(1) << 0) | (NK'(1) << 5);
    step(16);
    strobe = 8'h03;
    step(1);
    check("t4_row_or", row_out, 4'b0011);
    strobe = 8'h00;
    step(1);
    check("t4_row_idle", row_out, 4'b0000);
    keys_raw = '0;
    step(16);
    flush_sticky();

    // 5: pulse restart on the fast instance, back-to-back acceptances on the main one
    run_b = 0; max_run_b = 0; n_low_b = 0;
    keys_b = NK'(1);
    step(2);
    keys_b = NK'(3);
    step(12);
    check("t5_restart_run", max_run_b, 5);
    check("t5_restart_total", n_low_b, 5);
    check("t5_b_key_any", key_any_b, 1'b1);
    check("t5_b_row", row_b, 4'b0000);
    keys_raw = NK'(1) << 12;
    step(4);
    keys_raw = (NK'(1) << 12) | (NK'(1) << 13);
    step(16);
    keys_raw = '0;
    step(16);
    flush_sticky();

`ifdef KEY_STICKY_EN
    // 6: short press seen once through the sticky bit
    keys_raw = NK'(1) << 4;
    step(16);
    keys_raw = '0;
    step(16);
    strobe = 8'h02;
    step(1);
    check("t6_sticky_row", row_out, 4'b0001);
    strobe = 8'h00;
    step(1);
    strobe = 8'h02;
    step(1);
    check("t6_sticky_clr", row_out, 4'b0000);
    strobe = '0;
    step(1);
`endif

    // Reset in the middle of a pulse, key held through reset
    keys_raw = NK'(1) << 20;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (int_n === 1'b0) found = 1'b1;
    end
    check("pulse_seen", found, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_imm_int_n", int_n, 1'b1);
    step(2);
    reset = 1'b0;
    n_int_low = 0;
    step(16);
    check("reaccept_one_pulse", n_int_low, 2);
    check("reaccept_key_any", key_any, 1'b1);

    // Randomized keys, strobes and occasional resets
    for (int it = 0; it < 60; it++) begin
      keys_raw = NK'($urandom());
      if ($urandom_range(0, 3) == 0) keys_raw = keys_raw & NK'($urandom());
      for (int j = 0; j < int'($urandom_range(1, 20)); j++) begin
        strobe = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, COLS - 1));
        if ($urandom_range(0, 7) == 0) strobe = 8'($urandom());
        reset = ($urandom_range(0, 63) == 0);
        step(1);
      end
      reset = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
